sec_ded_enc_stream: RTL and testbench

//  Streaming SEC-DED encoder: 32-bit data words become 39-bit codewords (32 data + 6 Hamming + 1 overall parity).
//  It is the transmit-side counterpart of sec_ded_dec_top/corrector, and its codeword layout is bit-exact with theirs.
//  It sits between a data source and a storage or link.

---
 rtl/sec_ded_enc_stream.sv | 241 ++++++++++++++++++++++++
 tb/tb_sec_ded_enc_stream.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sec_ded_enc_stream.sv
// ----------------------------------------------------------------------------
// sec_ded_enc_stream
//
// Streaming SEC-DED encoder. Each 32-bit data word becomes a 39-bit codeword:
// 32 data bits, 6 Hamming parity bits and one overall parity bit. The layout
// is bit-exact with the sec_ded_dec_top / corrector receive path:
//   out[i], i = 1..38   Hamming position i
//   parity bits         positions 1, 2, 4, 8, 16, 32
//   data bits           in[0] -> position 3, then ascending through the
//                       remaining non-power-of-two positions up to 38
//   out[0]              XOR of out[38:1] (even parity over all 39 bits)
//
// Data path: input handshake -> 2-entry skid buffer -> optional middle
// pipeline register -> registered output stage. A word arriving while the
// path is empty bypasses the skid buffer. in_rdy is a flop and drops exactly
// when both skid entries are occupied.
//
// Parameters
//   PIPE_STAGES  1 or 2; latency from input accept to out_vld. 2 adds a
//                middle register. Any other value builds as 1.
//   CNT_W        width of the transferred-codeword counter wcnt
//
// Ports
//   clk       in   1      clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   in        in   32     data word
//   in_vld    in   1      in is valid
//   in_rdy    out  1      encoder accepts; transfer on in_vld & in_rdy
//   out       out  39     codeword; holds its value while not transferring
//   out_vld   out  1      out is valid
//   out_rdy   in   1      sink accepts; transfer on out_vld & out_rdy
//   wcnt      out  CNT_W  codewords transferred on out (wraps)
//   busy      out  1      any pipeline register or skid entry holds a word
//
// Optional feature, macro SEC_DED_ERR_INJ_EN:
//   inj_arm   in   1      one-cycle pulse latching inj_mask and arming
//   inj_mask  in   39     XOR mask applied to the next accepted codeword
//   The injection is one-shot; re-arming while armed replaces the mask.
//   Without the macro these ports and all injection logic are absent.
// ----------------------------------------------------------------------------
module sec_ded_enc_stream #(
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      in,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [38:0]      out,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [CNT_W-1:0] wcnt,
    output logic             busy
`ifdef SEC_DED_ERR_INJ_EN
    ,
    input  logic             inj_arm,
    input  logic [38:0]      inj_mask
`endif
);

    // Hamming encode. Data bits are scattered into the non-power-of-two
    // positions first, then each parity bit 2^k covers every data position
    // whose index has bit k set, then the overall parity closes it off.
    function automatic logic [38:0] sec_ded_encode(input logic [31:0] data);
        logic [38:0] cw;
        logic        par;
        int          di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos < 39; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = data[di];
                di++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            par = 1'b0;
            for (int pos = 1; pos < 39; pos++) begin
                if ((((pos >> k) & 1) != 0) && ((pos & (pos - 1)) != 0)) begin
                    par = par ^ cw[pos];
                end
            end
            cw[1 << k] = par;
        end
        cw[0] = ^cw[38:1];
        return cw;
    endfunction

    logic              in_rdy_q;
    logic              in_fire;
    logic [38:0]       in_cw;

    logic [38:0]       skid_mem [2];
    logic              skid_wr;
    logic              skid_rd;
    logic [1:0]        skid_cnt;
    logic [1:0]        skid_cnt_nxt;
    logic              skid_empty;
    logic              skid_push;
    logic              skid_pop;

    logic              src_vld;
    logic [38:0]       src_dat;
    logic              head_free;
    logic              feed_vld;
    logic [38:0]       feed_dat;
    logic              mid_busy;

    logic              out_vld_q;
    logic [38:0]       out_q;
    logic              out_free;
    logic [CNT_W-1:0]  wcnt_q;

    assign in_fire = in_vld & in_rdy_q;

`ifdef SEC_DED_ERR_INJ_EN
    logic              inj_armed;
    logic [38:0]       inj_mask_q;

    // An arm pulse takes priority over the disarm, so an arm in the same
    // cycle as an accept applies to the following word, not this one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_armed  <= 1'b0;
            inj_mask_q <= '0;
        end else if (inj_arm) begin
            inj_armed  <= 1'b1;
            inj_mask_q <= inj_mask;
        end else if (in_fire && inj_armed) begin
            inj_armed  <= 1'b0;
        end
    end

    // The mask is folded in at accept time so the skid entry carries the
    // already-corrupted codeword and a later re-arm cannot affect it.
    assign in_cw = sec_ded_encode(in) ^ (inj_armed ? inj_mask_q : 39'h0);
`else
    assign in_cw = sec_ded_encode(in);
`endif

    // Source for the first pipeline register: the oldest skid entry if any,
    // otherwise the word being accepted right now (bypass). A new word goes
    // into the skid buffer whenever it cannot move straight on.
    always_comb begin
        skid_empty   = (skid_cnt == 2'd0);
        src_vld      = !skid_empty | in_fire;
        src_dat      = skid_empty ? in_cw : skid_mem[skid_rd];
        skid_pop     = !skid_empty & head_free;
        skid_push    = in_fire & !(skid_empty & head_free);
        skid_cnt_nxt = skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};
    end

    // in_rdy is computed from next-cycle occupancy so it is a pure flop
    // output yet still reads low exactly when both entries are filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
            skid_wr     <= 1'b0;
            skid_rd     <= 1'b0;
            skid_cnt    <= 2'd0;
            in_rdy_q    <= 1'b0;
        end else begin
            if (skid_push) begin
                skid_mem[skid_wr] <= in_cw;
                skid_wr           <= ~skid_wr;
            end
            if (skid_pop) begin
                skid_rd <= ~skid_rd;
            end
            skid_cnt <= skid_cnt_nxt;
            in_rdy_q <= (skid_cnt_nxt != 2'd2);
        end
    end

    assign out_free = !out_vld_q | out_rdy;

    generate
        if (PIPE_STAGES == 2) begin : g_pipe2
            logic        mid_vld;
            logic [38:0] mid_dat;
            logic        mid_free;

            assign mid_free = !mid_vld | out_free;

            // Middle register; data only loads with a valid word so stale
            // contents never leak through as X or garbage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mid_vld <= 1'b0;
                    mid_dat <= '0;
                end else if (mid_free) begin
                    mid_vld <= src_vld;
                    if (src_vld) begin
                        mid_dat <= src_dat;
                    end
                end
            end

            assign head_free = mid_free;
            assign feed_vld  = mid_vld;
            assign feed_dat  = mid_dat;
            assign mid_busy  = mid_vld;
        end else begin : g_pipe1
            assign head_free = out_free;
            assign feed_vld  = src_vld;
            assign feed_dat  = src_dat;
            assign mid_busy  = 1'b0;
        end
    endgenerate

    // Output register. It only changes when empty or transferring, and its
    // data only when a valid word replaces it, so out holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else if (out_free) begin
            out_vld_q <= feed_vld;
            if (feed_vld) begin
                out_q <= feed_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else if (out_vld_q && out_rdy) begin
            wcnt_q <= wcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out     = out_q;
    assign out_vld = out_vld_q;
    assign wcnt    = wcnt_q;
    assign busy    = out_vld_q | mid_busy | !skid_empty;

endmodule

// File: tb/tb_sec_ded_enc_stream.sv
// ----------------------------------------------------------------------------
// tb_sec_ded_enc_stream
//
// Directed bench for sec_ded_enc_stream built with PIPE_STAGES=1, CNT_W=4 so
// that counter wrap is reachable in a few transfers. Expected codewords are
// hand-derived constants from the Hamming position layout.
// ----------------------------------------------------------------------------
module tb_sec_ded_enc_stream;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic        in_vld;
    logic        in_rdy;
    logic [38:0] out;
    logic        out_vld;
    logic        out_rdy;
    logic [3:0]  wcnt;
    logic        busy;
`ifdef SEC_DED_ERR_INJ_EN
    logic        inj_arm;
    logic [38:0] inj_mask;
`endif

    int tests_run;
    int fail_count;

    logic [31:0] vec    [9];
    logic [38:0] exp_cw [9];

    sec_ded_enc_stream #(
        .PIPE_STAGES (1),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (din),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out      (out),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .wcnt     (wcnt),
        .busy     (busy)
`ifdef SEC_DED_ERR_INJ_EN
        ,
        .inj_arm  (inj_arm),
        .inj_mask (inj_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic vld, input logic ordy);
        din     = data;
        in_vld  = vld;
        out_rdy = ordy;
    endtask

    task automatic checkOutput(input string tag, input logic [38:0] observed, input logic [38:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        int in_idx;
        int out_idx;

        tests_run  = 0;
        fail_count = 0;

        vec[0] = 32'h0000_0000;  exp_cw[0] = 39'h00_0000_0000;
        vec[1] = 32'h0000_0001;  exp_cw[1] = 39'h00_0000_000F;
        vec[2] = 32'h0000_0002;  exp_cw[2] = 39'h00_0000_0033;
        vec[3] = 32'h0000_0003;  exp_cw[3] = 39'h00_0000_003C;
        vec[4] = 32'h0000_0004;  exp_cw[4] = 39'h00_0000_0055;
        vec[5] = 32'h0000_0008;  exp_cw[5] = 39'h00_0000_0096;
        vec[6] = 32'h0000_0010;  exp_cw[6] = 39'h00_0000_0303;
        vec[7] = 32'h8000_0000;  exp_cw[7] = 39'h41_0000_0014;
        vec[8] = 32'hFFFF_FFFF;  exp_cw[8] = 39'h7E_FFFF_FFE8;

`ifdef SEC_DED_ERR_INJ_EN
        inj_arm  = 1'b0;
        inj_mask = '0;
`endif
        rst_n = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0);
        #2;

        // Reset values
        checkOutput("rst_out_vld", {38'b0, out_vld}, 39'h0);
        checkOutput("rst_in_rdy",  {38'b0, in_rdy},  39'h0);
        checkOutput("rst_out",     out,              39'h0);
        checkOutput("rst_wcnt",    {35'b0, wcnt},    39'h0);
        checkOutput("rst_busy",    {38'b0, busy},    39'h0);

        waitCycle();
        waitCycle();
        rst_n = 1'b1;
        waitCycle();
        checkOutput("rel_in_rdy", {38'b0, in_rdy}, 39'h1);

        // Single zero word
        applyStimulus(32'h0, 1'b1, 1'b1);
        waitCycle();
        applyStimulus(32'h0, 1'b0, 1'b1);
        checkOutput("zero_vld",  {38'b0, out_vld}, 39'h1);
        checkOutput("zero_out",  out,              39'h0);
        checkOutput("zero_busy", {38'b0, busy},    39'h1);
        waitCycle();
        checkOutput("zero_vld_drop", {38'b0, out_vld}, 39'h0);
        checkOutput("zero_wcnt",     {35'b0, wcnt},    39'h1);
        checkOutput("zero_idle",     {38'b0, busy},    39'h0);

        // Back-to-back 1 then 2
        applyStimulus(32'h1, 1'b1, 1'b1);
        waitCycle();
        applyStimulus(32'h2, 1'b1, 1'b1);
        checkOutput("b2b_first", out, 39'h0F);
        waitCycle();
        applyStimulus(32'h0, 1'b0, 1'b1);
        checkOutput("b2b_second",     out,              39'h33);
        checkOutput("b2b_second_vld", {38'b0, out_vld}, 39'h1);
        waitCycle();
        checkOutput("b2b_wcnt", {35'b0, wcnt}, 39'h3);

        // Full vector table at one word per cycle
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vec[i], 1'b1, 1'b1);
            waitCycle();
            checkOutput("table_cw", out, exp_cw[i]);
        end
        applyStimulus(32'h0, 1'b0, 1'b1);
        waitCycle();
        checkOutput("table_vld_drop", {38'b0, out_vld}, 39'h0);
        checkOutput("table_out_hold", out,              exp_cw[8]);
        checkOutput("table_wcnt",     {35'b0, wcnt},    39'hC);

        // Output stall for 5 cycles: out register plus two skid entries fill
        applyStimulus(vec[1], 1'b1, 1'b0);
        checkOutput("stall_rdy0", {38'b0, in_rdy}, 39'h1);
        waitCycle();
        applyStimulus(vec[2], 1'b1, 1'b0);
        checkOutput("stall_rdy1", {38'b0, in_rdy},  39'h1);
        checkOutput("stall_vld1", {38'b0, out_vld}, 39'h1);
        checkOutput("stall_out1", out,              exp_cw[1]);
        waitCycle();
        applyStimulus(vec[3], 1'b1, 1'b0);
        checkOutput("stall_rdy2", {38'b0, in_rdy}, 39'h1);
        checkOutput("stall_out2", out,             exp_cw[1]);
        waitCycle();
        applyStimulus(vec[4], 1'b1, 1'b0);
        checkOutput("stall_full3", {38'b0, in_rdy}, 39'h0);
        checkOutput("stall_out3",  out,             exp_cw[1]);
        checkOutput("stall_busy3", {38'b0, busy},   39'h1);
        waitCycle();
        checkOutput("stall_full4", {38'b0, in_rdy}, 39'h0);
        checkOutput("stall_out4",  out,             exp_cw[1]);
        waitCycle();

        // Drain with out_rdy=1 while the remaining words keep arriving
        in_idx  = 3;
        out_idx = 0;
        for (int c = 0; c < 40 && out_idx < 6; c++) begin
            if (in_idx < 6) applyStimulus(vec[1 + in_idx], 1'b1, 1'b1);
            else            applyStimulus(32'h0, 1'b0, 1'b1);
            if (out_vld) begin
                checkOutput("stall_order", out, exp_cw[1 + out_idx]);
                out_idx++;
            end
            if (in_vld && in_rdy) in_idx++;
            waitCycle();
        end
        applyStimulus(32'h0, 1'b0, 1'b1);
        checkOutput("stall_drained", 39'(out_idx), 39'h6);
        checkOutput("stall_no_dup",  {38'b0, out_vld}, 39'h0);
        checkOutput("stall_idle",    {38'b0, busy},    39'h0);
        checkOutput("stall_wrap",    {35'b0, wcnt},    39'h2);

        // Reset while words are in flight
        applyStimulus(vec[8], 1'b1, 1'b0);
        waitCycle();
        applyStimulus(vec[7], 1'b1, 1'b0);
        waitCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_vld",  {38'b0, out_vld}, 39'h0);
        checkOutput("midrst_out",  out,              39'h0);
        checkOutput("midrst_wcnt", {35'b0, wcnt},    39'h0);
        checkOutput("midrst_busy", {38'b0, busy},    39'h0);
        checkOutput("midrst_rdy",  {38'b0, in_rdy},  39'h0);
        applyStimulus(32'h0, 1'b0, 1'b1);
        waitCycle();
        rst_n = 1'b1;
        waitCycle();
        checkOutput("postrst_rdy",  {38'b0, in_rdy},  39'h1);
        checkOutput("postrst_vld",  {38'b0, out_vld}, 39'h0);
        checkOutput("postrst_busy", {38'b0, busy},    39'h0);

        // Seventeen transfers wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vec[i % 9], 1'b1, 1'b1);
            waitCycle();
            checkOutput("wrap_cw", out, exp_cw[i % 9]);
        end
        applyStimulus(32'h0, 1'b0, 1'b1);
        waitCycle();
        checkOutput("wrap_wcnt", {35'b0, wcnt},    39'h1);
        checkOutput("wrap_vld",  {38'b0, out_vld}, 39'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
